ysyx_24110015_pipe_ctrl: RTL and testbench
==========================================

YSYX_24110015_PIPE_CTRL -- requirements
Module: ysyx_24110015_pipe_ctrl

Interface
REQ-001 SHALL have parameter: CNT_W, 32, width of performance counters.
REQ-002 SHALL have port: clk  in  1  single clock; all state on rising edge.
REQ-003 SHALL have port: rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: if_valid  in  1  IFU holds fetched instruction; if_ready  out  1  ID can accept it.
REQ-005 SHALL have ports: id_rs1, id_rs2  in  5 each  source regs of incoming instruction; id_rs1_used, id_rs2_used  in  1 each.
REQ-006 SHALL have ports: id_rd  in  5  dest reg; id_rd_wen  in  1; id_mem  in  1  instruction is load/store.
REQ-007 SHALL have ports: ex_redirect  in  1  EX instruction changes PC (taken branch, jump, trap, mret); ls_done  in  1  LSU transaction complete pulse.
REQ-008 SHALL have ports: id_en, ex_en, ls_en, wb_en  out  1 each  stage-register load enables.
REQ-009 SHALL have ports: id_valid, ex_valid, ls_valid, wb_valid  out  1 each; if_flush  out  1  IFU discards fetch, takes redirect PC.
REQ-010 SHALL have ports: rf_wen  out  1  regfile write strobe; stall_cnt, instret_cnt  out  CNT_W each.

Function
REQ-011 SHALL hold per stage (ID, EX, LS, WB): valid bit, rd, rd_wen, mem flag; fields copied stage-to-stage on enable.
REQ-012 SHALL compute ls_ready = !ls_valid | !ls_mem | ls_done; ex_ready = !ex_valid | ls_ready; WB always drains in one cycle.
REQ-013 SHALL assert hazard when ID valid and a used rs (nonzero) equals rd of any valid EX, LS or WB entry with rd_wen=1; rs=x0 never hazards.
REQ-014 SHALL compute id_fire = id_valid & !hazard & ex_ready; if_ready = !id_valid | id_fire, forced 0 in redirect cycle.
REQ-015 SHALL load ID (id_en=1) on if_valid & if_ready; ID valid clears when id_fire without new load.
REQ-016 SHALL set ex_en = id_fire; on ex_ready with no id_fire, EX becomes bubble (valid 0).
REQ-017 SHALL set ls_en when EX valid & ls_ready; LS becomes bubble when LS advances without EX entry.
REQ-018 SHALL set wb_en when LS valid & ls_ready; wb_valid lasts exactly one cycle per instruction.
REQ-019 SHALL assert rf_wen = wb_valid & wb_rd_wen & (wb_rd != 0).
REQ-020 SHALL honour ex_redirect only in the cycle EX advances to LS; then pulse if_flush one cycle, clear ID valid, block ID load that cycle; EX instruction itself proceeds.
REQ-021 SHALL give redirect priority over hazard and over a simultaneous if_valid handshake (instruction dropped).
REQ-022 SHALL increment stall_cnt each cycle id_valid & hazard, instret_cnt each cycle wb_valid; both wrap modulo 2^CNT_W.
REQ-023 SHALL add no combinational path from if_valid to ex_en/ls_en/wb_en.

Reset
REQ-024 SHALL, while rst low, clear all valid bits, stage fields and counters; all outputs read 0 (if_ready included).
REQ-025 SHALL, on reset mid-operation, abandon in-flight instructions; first if_ready=1 on first clk edge after rst rises.

Structure
REQ-026 SHALL take stage-field struct (rd, rd_wen, mem) and stage-index constants from shared package ysyx_24110015_pkg.
REQ-027 SHALL implement hazard comparison in one combinational sub-module ysyx_24110015_hazard.

Verification
REQ-028 SHALL cover: independent ALU stream, if_valid held 1 -> after 4-cycle fill wb_valid every cycle, instret_cnt=10 after 10 retirements, stall_cnt=0.
REQ-029 SHALL cover: addi x5 then add x6,x5,x5 -> ID held 3 cycles (EX, LS, WB occupancy), stall_cnt=3, rf_wen for x5 precedes EX of add.
REQ-030 SHALL cover: load in LS with ls_done after 5 cycles -> ex/id frozen 5 cycles, wb_valid one cycle after ls_done, no instruction lost or duplicated.
REQ-031 SHALL cover: taken branch with ex_redirect while ID valid and if_valid=1 -> if_flush one cycle, ID and fetched instruction never reach EX.
REQ-032 SHALL cover: rd=x0 writer followed by x0 reader -> no stall, rf_wen=0.
REQ-033 SHALL cover: rst low for 2 cycles during load stall -> all valids 0, counters 0, clean restart fetch.

Source files
------------

// File: rtl/ysyx_24110015_pkg.sv
// Shared pipeline-control types: per-stage bookkeeping fields
// and stage indices used to address the stage arrays.
package ysyx_24110015_pkg;

  typedef struct packed {
    logic [4:0] rd;
    logic       rd_wen;
    logic       mem;
  } stage_t;

  localparam int STG_ID = 0;
  localparam int STG_EX = 1;
  localparam int STG_LS = 2;
  localparam int STG_WB = 3;
  localparam int NSTG   = 4;

  localparam stage_t STAGE_NULL = '0;

endpackage

// File: rtl/ysyx_24110015_hazard.sv
// RAW hazard detect: ID sources vs. pending EX/LS/WB writers.
// Ports: id_valid, rs1/rs2 + used flags, wr_en/wr_rd per stage, hazard.
import ysyx_24110015_pkg::*;

module ysyx_24110015_hazard (
  input  logic                        id_valid,
  input  logic [4:0]                  rs1,
  input  logic [4:0]                  rs2,
  input  logic                        rs1_used,
  input  logic                        rs2_used,
  input  logic [STG_WB:STG_EX]        wr_en,
  input  logic [STG_WB:STG_EX][4:0]   wr_rd,
  output logic                        hazard
);

  logic hit1;
  logic hit2;

  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int s = STG_EX; s <= STG_WB; s++) begin
      if (wr_en[s] && (wr_rd[s] == rs1)) hit1 = 1'b1;
      if (wr_en[s] && (wr_rd[s] == rs2)) hit2 = 1'b1;
    end
    // x0 is hardwired, so reading it never waits
    hazard = id_valid &
             ((rs1_used & (rs1 != 5'd0) & hit1) |
              (rs2_used & (rs2 != 5'd0) & hit2));
  end

endmodule

// File: rtl/ysyx_24110015_pipe_ctrl.sv
// In-order 4-stage (ID/EX/LS/WB) pipeline controller with stalls,
// redirect flush and perf counters. Ports: IFU handshake, ID decode
// fields, ex_redirect/ls_done, stage enables/valids, rf_wen, counters.
import ysyx_24110015_pkg::*;

module ysyx_24110015_pipe_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  output logic             if_ready,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       id_rd,
  input  logic             id_rd_wen,
  input  logic             id_mem,
  input  logic             ex_redirect,
  input  logic             ls_done,
  output logic             id_en,
  output logic             ex_en,
  output logic             ls_en,
  output logic             wb_en,
  output logic             id_valid,
  output logic             ex_valid,
  output logic             ls_valid,
  output logic             wb_valid,
  output logic             if_flush,
  output logic             rf_wen,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  logic [NSTG-1:0] vld;
  stage_t          stg [NSTG];
  logic [4:0]      src1;
  logic [4:0]      src2;
  logic            src1_used;
  logic            src2_used;
  // low until the first edge after reset release
  logic            run;

  logic ls_ready;
  logic ex_ready;
  logic redirect;
  logic hazard;
  logic id_fire;

  logic [STG_WB:STG_EX]      wr_en;
  logic [STG_WB:STG_EX][4:0] wr_rd;

  always_comb begin
    wr_en = '0;
    wr_rd = '0;
    for (int s = STG_EX; s <= STG_WB; s++) begin
      wr_en[s] = vld[s] & stg[s].rd_wen;
      wr_rd[s] = stg[s].rd;
    end
  end

  ysyx_24110015_hazard u_hazard (
    .id_valid (vld[STG_ID]),
    .rs1      (src1),
    .rs2      (src2),
    .rs1_used (src1_used),
    .rs2_used (src2_used),
    .wr_en    (wr_en),
    .wr_rd    (wr_rd),
    .hazard   (hazard)
  );

  assign ls_ready = !vld[STG_LS] | !stg[STG_LS].mem | ls_done;
  assign ex_ready = !vld[STG_EX] | ls_ready;
  // redirect acts only when the EX entry actually moves on
  assign redirect = vld[STG_EX] & ex_redirect & ls_ready;
  assign id_fire  = vld[STG_ID] & !hazard & ex_ready & !redirect;
  assign if_ready = run & (!vld[STG_ID] | id_fire) & !redirect;

  assign id_en    = if_valid & if_ready;
  assign ex_en    = id_fire;
  assign ls_en    = vld[STG_EX] & ls_ready;
  assign wb_en    = vld[STG_LS] & ls_ready;
  assign if_flush = redirect;

  assign id_valid = vld[STG_ID];
  assign ex_valid = vld[STG_EX];
  assign ls_valid = vld[STG_LS];
  assign wb_valid = vld[STG_WB];
  assign rf_wen   = vld[STG_WB] & stg[STG_WB].rd_wen &
                    (stg[STG_WB].rd != 5'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run         <= 1'b0;
      vld         <= '0;
      src1        <= '0;
      src2        <= '0;
      src1_used   <= 1'b0;
      src2_used   <= 1'b0;
      stall_cnt   <= '0;
      instret_cnt <= '0;
      for (int s = 0; s < NSTG; s++) stg[s] <= STAGE_NULL;
    end else begin
      run <= 1'b1;

      if (redirect) begin
        vld[STG_ID] <= 1'b0;
      end else if (id_en) begin
        vld[STG_ID] <= 1'b1;
        stg[STG_ID] <= '{rd: id_rd, rd_wen: id_rd_wen, mem: id_mem};
        src1        <= id_rs1;
        src2        <= id_rs2;
        src1_used   <= id_rs1_used;
        src2_used   <= id_rs2_used;
      end else if (id_fire) begin
        vld[STG_ID] <= 1'b0;
      end

      if (ex_ready) begin
        vld[STG_EX] <= id_fire;
        if (id_fire) stg[STG_EX] <= stg[STG_ID];
      end

      if (ls_ready) begin
        vld[STG_LS] <= vld[STG_EX];
        if (ls_en) stg[STG_LS] <= stg[STG_EX];
      end

      vld[STG_WB] <= wb_en;
      if (wb_en) stg[STG_WB] <= stg[STG_LS];

      if (hazard)      stall_cnt   <= stall_cnt + CNT_W'(1);
      if (vld[STG_WB]) instret_cnt <= instret_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ysyx_24110015_pipe_ctrl.sv
// Directed bench for ysyx_24110015_pipe_ctrl: fill, RAW stall,
// load wait, redirect flush, x0 handling and mid-run reset.
module tb_ysyx_24110015_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic        if_ready;
  logic [4:0]  id_rs1, id_rs2;
  logic        id_rs1_used, id_rs2_used;
  logic [4:0]  id_rd;
  logic        id_rd_wen, id_mem;
  logic        ex_redirect, ls_done;
  logic        id_en, ex_en, ls_en, wb_en;
  logic        id_valid, ex_valid, ls_valid, wb_valid;
  logic        if_flush, rf_wen;
  logic [31:0] stall_cnt, instret_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  ysyx_24110015_pipe_ctrl #(.CNT_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .id_rd       (id_rd),
    .id_rd_wen   (id_rd_wen),
    .id_mem      (id_mem),
    .ex_redirect (ex_redirect),
    .ls_done     (ls_done),
    .id_en       (id_en),
    .ex_en       (ex_en),
    .ls_en       (ls_en),
    .wb_en       (wb_en),
    .id_valid    (id_valid),
    .ex_valid    (ex_valid),
    .ls_valid    (ls_valid),
    .wb_valid    (wb_valid),
    .if_flush    (if_flush),
    .rf_wen      (rf_wen),
    .stall_cnt   (stall_cnt),
    .instret_cnt (instret_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input logic v, input logic [4:0] rd,
                       input logic wen, input logic mem,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input logic u1, input logic u2);
    if_valid    = v;
    id_rd       = rd;
    id_rd_wen   = wen;
    id_mem      = mem;
    id_rs1      = r1;
    id_rs2      = r2;
    id_rs1_used = u1;
    id_rs2_used = u2;
  endtask

  task automatic idle();
    fetch(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  // two edges in reset, release, one edge to enable fetch
  task automatic do_reset();
    idle();
    ex_redirect = 1'b0;
    ls_done     = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b0;
    ex_redirect = 1'b0;
    ls_done = 1'b0;
    fetch(1'b1, 5'd1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);

    // ---- reset state
    #3;
    chk("rst_if_ready", if_ready, 1'b0);
    chk("rst_id_en", id_en, 1'b0);
    chk("rst_valids", {id_valid, ex_valid, ls_valid, wb_valid}, 4'b0);
    chk("rst_stall", stall_cnt, 32'd0);
    chk("rst_instret", instret_cnt, 32'd0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rel_if_ready_pre", if_ready, 1'b0);
    tick();

    // ---- independent stream, if_valid held for 10 fetches
    for (int c = 0; c < 15; c++) begin
      fetch(c < 10, 5'(c + 1), 1'b1, 1'b0,
            5'd0, 5'd0, 1'b0, 1'b0);
      #1;
      chk("s_wb", wb_valid, (c >= 4 && c <= 13));
      chk("s_rf", rf_wen, (c >= 4 && c <= 13));
      if (c < 10) chk("s_ifr", if_ready, 1'b1);
      tick();
    end
    chk("s_instret", instret_cnt, 32'd10);
    chk("s_stall", stall_cnt, 32'd0);

    // ---- RAW: addi x5 ; add x6,x5,x5
    do_reset();
    fetch(1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    #1 chk("raw_c0_ifr", if_ready, 1'b1);
    tick();
    fetch(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 5'd5, 1'b1, 1'b1);
    #1 chk("raw_c1_exen", ex_en, 1'b1);
    tick();
    idle();
    #1;
    chk("raw_c2_exen", ex_en, 1'b0);
    chk("raw_c2_ifr", if_ready, 1'b0);
    chk("raw_c2_idv", id_valid, 1'b1);
    tick();
    #1;
    chk("raw_c3_bubble", ex_valid, 1'b0);
    chk("raw_c3_lsv", ls_valid, 1'b1);
    tick();
    #1;
    chk("raw_c4_rfwen", rf_wen, 1'b1);
    chk("raw_c4_exen", ex_en, 1'b0);
    tick();
    #1;
    chk("raw_c5_exen", ex_en, 1'b1);
    chk("raw_c5_stall", stall_cnt, 32'd3);
    tick();
    tick();
    tick();
    #1;
    chk("raw_c8_wb", wb_valid, 1'b1);
    chk("raw_c8_rf", rf_wen, 1'b1);
    tick();
    #1;
    chk("raw_instret", instret_cnt, 32'd2);
    chk("raw_stall", stall_cnt, 32'd3);

    // ---- load held in LS for 5 frozen cycles
    do_reset();
    fetch(1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    fetch(1'b1, 5'd8, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    fetch(1'b1, 5'd9, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    #1 chk("ld_c2_ifr", if_ready, 1'b1);
    tick();
    idle();
    for (int c = 3; c < 8; c++) begin
      #1;
      chk("ld_frz_exen", ex_en, 1'b0);
      chk("ld_frz_lsen", ls_en, 1'b0);
      chk("ld_frz_wb", wb_valid, 1'b0);
      chk("ld_frz_ifr", if_ready, 1'b0);
      chk("ld_frz_v", {id_valid, ex_valid, ls_valid}, 3'b111);
      tick();
    end
    ls_done = 1'b1;
    #1;
    chk("ld_c8_en", {ex_en, ls_en, wb_en}, 3'b111);
    chk("ld_c8_wb", wb_valid, 1'b0);
    tick();
    ls_done = 1'b0;
    #1;
    chk("ld_c9_wb", wb_valid, 1'b1);
    chk("ld_c9_rf", rf_wen, 1'b1);
    tick();
    #1 chk("ld_c10_wb", wb_valid, 1'b1);
    tick();
    #1 chk("ld_c11_wb", wb_valid, 1'b1);
    tick();
    #1;
    chk("ld_c12_wb", wb_valid, 1'b0);
    chk("ld_instret", instret_cnt, 32'd3);
    chk("ld_stall", stall_cnt, 32'd0);

    // ---- taken branch flushes ID and the fetch in flight
    do_reset();
    fetch(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    fetch(1'b1, 5'd10, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    fetch(1'b1, 5'd11, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    ex_redirect = 1'b1;
    #1;
    chk("br_c2_flush", if_flush, 1'b1);
    chk("br_c2_ifr", if_ready, 1'b0);
    chk("br_c2_iden", id_en, 1'b0);
    chk("br_c2_exen", ex_en, 1'b0);
    chk("br_c2_lsen", ls_en, 1'b1);
    tick();
    ex_redirect = 1'b0;
    fetch(1'b1, 5'd12, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    #1;
    chk("br_c3_flush", if_flush, 1'b0);
    chk("br_c3_v", {id_valid, ex_valid, ls_valid}, 3'b001);
    chk("br_c3_ifr", if_ready, 1'b1);
    tick();
    idle();
    #1;
    chk("br_c4_wb", wb_valid, 1'b1);
    chk("br_c4_rf", rf_wen, 1'b0);
    chk("br_c4_exv", ex_valid, 1'b0);
    tick();
    #1;
    chk("br_c5_exv", ex_valid, 1'b1);
    chk("br_c5_wb", wb_valid, 1'b0);
    tick();
    tick();
    #1;
    chk("br_c7_wb", wb_valid, 1'b1);
    chk("br_c7_rf", rf_wen, 1'b1);
    tick();
    #1 chk("br_instret", instret_cnt, 32'd2);

    // ---- x0 writer then x0 reader
    do_reset();
    fetch(1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    fetch(1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1);
    tick();
    idle();
    #1 chk("x0_c2_exen", ex_en, 1'b1);
    tick();
    #1 chk("x0_c3_stall", stall_cnt, 32'd0);
    tick();
    #1;
    chk("x0_c4_wb", wb_valid, 1'b1);
    chk("x0_c4_rf", rf_wen, 1'b0);
    tick();
    #1;
    chk("x0_c5_rf", rf_wen, 1'b1);
    chk("x0_stall", stall_cnt, 32'd0);

    // ---- reset asserted during a load stall
    do_reset();
    fetch(1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    fetch(1'b1, 5'd8, 1'b1, 1'b0, 5'd7, 5'd0, 1'b1, 1'b0);
    tick();
    idle();
    tick();
    tick();
    #1;
    chk("mr_pre_stall", stall_cnt, 32'd2);
    chk("mr_pre_lsv", ls_valid, 1'b1);
    fetch(1'b1, 5'd4, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    chk("mr_v", {id_valid, ex_valid, ls_valid, wb_valid}, 4'b0);
    chk("mr_stall", stall_cnt, 32'd0);
    chk("mr_instret", instret_cnt, 32'd0);
    chk("mr_ifr", if_ready, 1'b0);
    chk("mr_iden", id_en, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    #1 chk("mr_rel_ifr", if_ready, 1'b0);
    tick();
    #1;
    chk("mr_r0_ifr", if_ready, 1'b1);
    chk("mr_r0_iden", id_en, 1'b1);
    tick();
    idle();
    #1 chk("mr_r1_v", {id_valid, ex_valid, ls_valid}, 3'b100);
    tick();
    tick();
    tick();
    #1;
    chk("mr_r4_wb", wb_valid, 1'b1);
    chk("mr_r4_rf", rf_wen, 1'b1);
    tick();
    #1;
    chk("mr_instret", instret_cnt, 32'd1);
    chk("mr_stall_end", stall_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
